// File: rtl/vga_frame_buf_pingpong.sv
// vga_frame_buf_pingpong: double-buffered frame store between a camera-capture writer and a VGA reader.
// Two DEPTH-word banks live in one inferred dual-port RAM. The writer fills one bank while the reader scans the other.
// Banks swap only when rd_frame_start arrives after a completed write frame, so the display never tears.
// Reads have a fixed latency of 2 cycles. An invalid read returns BLANK_VAL, but vga_pixel_vld still follows rd_en.
// Ports:
//   vga_bram_clk, vga_bram_rst_n      : single clock, asynchronous active-low reset
//   wr_frame_start/wr_frame_done      : writer frame delimiters (pulses)
//   wr_en, wr_addr, wr_data           : pixel write port (pixel index within frame)
//   rd_frame_start                    : reader vsync pulse, the only swap point
//   rd_en, rd_addr                    : pixel read port (active video)
//   vga_pixel, vga_pixel_vld          : registered read result, 2 cycles after rd_en
//   wr_bank, rd_bank, frame_avail     : bank ownership and "a frame has been shown" flag
//   frame_drop, wr_oob                : registered 1-cycle event pulses
module vga_frame_buf_pingpong #(
  parameter int               DATA_W    = 12,
  parameter int               ADDR_W    = 17,
  parameter int               DEPTH     = 76800,
  parameter logic [DATA_W-1:0] BLANK_VAL = '0
) (
  input  logic              vga_bram_clk,
  input  logic              vga_bram_rst_n,
  input  logic              wr_frame_start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              vga_pixel_vld,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_avail,
  output logic              frame_drop,
  output logic              wr_oob
);

  // The index width covers both banks exactly, so the RAM is not padded to a power of two.
  localparam int              RAM_AW  = $clog2(2 * DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FULL   = 2'd2;

  logic [DATA_W-1:0] r_ram [0:2*DEPTH-1];
  logic [DATA_W-1:0] r_ram_q;

  logic [1:0]        r_state;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic              r_frame_avail;
  logic              r_frame_drop;
  logic              r_wr_oob;
  logic              r_rd_ok;
  logic              r_rd_vld;
  logic [DATA_W-1:0] r_pixel;
  logic              r_pixel_vld;

  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_wr_ok;
  logic              w_swap;
  logic [ADDR_W:0]   w_wr_idx;
  logic [ADDR_W:0]   w_rd_idx;

  assign w_wr_in_range = {1'b0, wr_addr} < DEPTH_L;
  assign w_rd_in_range = {1'b0, rd_addr} < DEPTH_L;
  assign w_wr_ok       = (r_state == S_ACTIVE) && wr_en && w_wr_in_range;
  assign w_swap        = (r_state == S_FULL) && rd_frame_start;

  // Bank 1 sits above bank 0. An out-of-range read address is redirected to word 0 of the bank,
  // which keeps the RAM index legal. That data is then discarded by r_rd_ok.
  assign w_wr_idx = r_wr_bank ? (DEPTH_L + {1'b0, wr_addr}) : {1'b0, wr_addr};
  assign w_rd_idx = w_rd_in_range ? (r_rd_bank ? (DEPTH_L + {1'b0, rd_addr}) : {1'b0, rd_addr})
                                  : (r_rd_bank ? DEPTH_L : '0);

  // The RAM has no reset, so the tools can map it onto block RAM.
  // The two ports always address different banks, so no read-during-write case arises.
  always_ff @(posedge vga_bram_clk) begin
    if (w_wr_ok) r_ram[w_wr_idx[RAM_AW-1:0]] <= wr_data;
    r_ram_q <= r_ram[w_rd_idx[RAM_AW-1:0]];
  end

  always_ff @(posedge vga_bram_clk or negedge vga_bram_rst_n) begin
    if (!vga_bram_rst_n) begin
      r_state       <= S_IDLE;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b1;
      r_frame_avail <= 1'b0;
      r_frame_drop  <= 1'b0;
      r_wr_oob      <= 1'b0;
      r_rd_ok       <= 1'b0;
      r_rd_vld      <= 1'b0;
      r_pixel       <= BLANK_VAL;
      r_pixel_vld   <= 1'b0;
    end else begin
      r_wr_oob     <= (r_state == S_ACTIVE) && wr_en && !w_wr_in_range;
      // A new frame offered while one is still waiting for the reader is rejected.
      r_frame_drop <= (r_state == S_FULL) && wr_frame_start && !rd_frame_start;

      case (r_state)
        S_IDLE: if (wr_frame_start) r_state <= S_ACTIVE;
        // wr_frame_start here is only a restart: the bank and the state stay as they are.
        S_ACTIVE: if (wr_frame_done) r_state <= S_FULL;
        S_FULL: if (rd_frame_start) r_state <= wr_frame_start ? S_ACTIVE : S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_swap) begin
        r_rd_bank     <= r_wr_bank;
        r_wr_bank     <= ~r_wr_bank;
        r_frame_avail <= 1'b1;
      end

      // Stage 1 runs alongside the RAM read. Its qualifier is sampled against the bank state of the issue cycle.
      r_rd_ok     <= rd_en && w_rd_in_range && r_frame_avail;
      r_rd_vld    <= rd_en;
      r_pixel     <= r_rd_ok ? r_ram_q : BLANK_VAL;
      r_pixel_vld <= r_rd_vld;
    end
  end

  assign vga_pixel     = r_pixel;
  assign vga_pixel_vld = r_pixel_vld;
  assign wr_bank       = r_wr_bank;
  assign rd_bank       = r_rd_bank;
  assign frame_avail   = r_frame_avail;
  assign frame_drop    = r_frame_drop;
  assign wr_oob        = r_wr_oob;

endmodule

// File: tb/tb_vga_frame_buf_pingpong.sv
// Bench for vga_frame_buf_pingpong with DEPTH=16.
// A frame-level model is compared with every output on each clock cycle.
// Directed scenarios pin the model with literal values, then a random phase runs.
module tb_vga_frame_buf_pingpong;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 5;
  localparam int D      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_frame_start = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_frame_done = 1'b0;
  logic              rd_frame_start = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] vga_pixel;
  logic              vga_pixel_vld;
  logic              wr_bank;
  logic              rd_bank;
  logic              frame_avail;
  logic              frame_drop;
  logic              wr_oob;

  int n_checks = 0;
  int n_errors = 0;

  vga_frame_buf_pingpong #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(D), .BLANK_VAL('0)
  ) dut (
    .vga_bram_clk(clk), .vga_bram_rst_n(rst_n),
    .wr_frame_start(wr_frame_start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .vga_pixel(vga_pixel), .vga_pixel_vld(vga_pixel_vld),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_avail(frame_avail),
    .frame_drop(frame_drop), .wr_oob(wr_oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mem holds the known contents of both banks (-1 = never written, so the value is unknown).
  // pend_* is a read that has been issued but is not yet visible.
  // exp_* is what the outputs must show now.
  localparam int M_IDLE = 0, M_ACTIVE = 1, M_FULL = 2;
  int m_phase = M_IDLE;
  int m_wrb = 0, m_rdb = 1, m_avail = 0, m_drop = 0, m_oob = 0;
  int mem [0:2*D-1];
  int pend_v = 0, pend_p = 0, exp_v = 0, exp_p = 0;

  initial for (int k = 0; k < 2*D; k++) mem[k] = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = M_IDLE; m_wrb = 0; m_rdb = 1; m_avail = 0; m_drop = 0; m_oob = 0;
      pend_v = 0; pend_p = 0; exp_v = 0; exp_p = 0;
    end else begin
      exp_v = pend_v;
      exp_p = pend_p;
      pend_v = rd_en;
      pend_p = (rd_en && int'(rd_addr) < D && m_avail != 0) ? mem[m_rdb*D + int'(rd_addr)] : 0;
      m_oob  = (m_phase == M_ACTIVE && wr_en && int'(wr_addr) >= D) ? 1 : 0;
      m_drop = (m_phase == M_FULL && wr_frame_start && !rd_frame_start) ? 1 : 0;
      if (m_phase == M_ACTIVE && wr_en && int'(wr_addr) < D)
        mem[m_wrb*D + int'(wr_addr)] = int'(wr_data);
      if (m_phase == M_IDLE) begin
        if (wr_frame_start) m_phase = M_ACTIVE;
      end else if (m_phase == M_ACTIVE) begin
        if (wr_frame_done) m_phase = M_FULL;
      end else if (rd_frame_start) begin
        m_rdb = m_wrb; m_wrb = 1 - m_wrb; m_avail = 1;
        m_phase = wr_frame_start ? M_ACTIVE : M_IDLE;
      end
    end
  end

  // Compare process: every output against the model, on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("vld", int'(vga_pixel_vld), exp_v);
      if (exp_p >= 0) chk("pixel", int'(vga_pixel), exp_p);
      chk("wr_bank", int'(wr_bank), m_wrb);
      chk("rd_bank", int'(rd_bank), m_rdb);
      chk("frame_avail", int'(frame_avail), m_avail);
      chk("frame_drop", int'(frame_drop), m_drop);
      chk("wr_oob", int'(wr_oob), m_oob);
    end
  end

  // Advance to the next falling edge and clear all strobes.
  // The caller then sets the inputs for the following rising edge.
  task automatic nxt();
    @(negedge clk);
    wr_frame_start = 1'b0; wr_frame_done = 1'b0; rd_frame_start = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic write_frame(input int base);
    nxt(); wr_frame_start = 1'b1;
    for (int i = 0; i < D; i++) begin
      nxt(); wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i + base);
    end
  endtask

  task automatic read_check(input int addr, input int exp_pix, input string nm);
    rd_en = 1'b1; rd_addr = ADDR_W'(addr);
    nxt();
    nxt();
    chk({nm, "_vld"}, int'(vga_pixel_vld), 1);
    chk(nm, int'(vga_pixel), exp_pix);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nxt();
    chk("rst_wr_bank", int'(wr_bank), 0);
    chk("rst_rd_bank", int'(rd_bank), 1);
    chk("rst_avail", int'(frame_avail), 0);
    chk("rst_vld", int'(vga_pixel_vld), 0);

    // A read before any frame: valid at +2, blank pixel.
    rd_en = 1'b1; rd_addr = '0;
    nxt(); chk("lat_vld_early", int'(vga_pixel_vld), 0);
    nxt(); chk("lat_vld", int'(vga_pixel_vld), 1);
    chk("lat_pixel_blank", int'(vga_pixel), 0);
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1; rd_addr = ADDR_W'(i); nxt();
    end

    // First frame into bank 0, then swap.
    write_frame(0);
    nxt(); wr_frame_done = 1'b1;
    nxt(); rd_frame_start = 1'b1;
    nxt();
    chk("swap1_rd_bank", int'(rd_bank), 0);
    chk("swap1_wr_bank", int'(wr_bank), 1);
    chk("swap1_avail", int'(frame_avail), 1);
    read_check(5, 5, "swap1_pix");

    // Bank 1 filled. A second start while FULL is dropped, and its write is ignored.
    write_frame(100);
    nxt(); wr_frame_done = 1'b1;
    nxt(); wr_frame_start = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 12'hABC;
    nxt(); chk("drop_pulse", int'(frame_drop), 1);
    nxt(); chk("drop_clear", int'(frame_drop), 0);
    chk("drop_rd_bank", int'(rd_bank), 0);
    rd_frame_start = 1'b1;
    nxt(); chk("swap2_rd_bank", int'(rd_bank), 1);
    read_check(3, 103, "drop_nowrite");

    // wr_frame_done and rd_frame_start in the same cycle: the swap is deferred to the next vsync.
    write_frame(200);
    nxt(); wr_frame_done = 1'b1; rd_frame_start = 1'b1;
    nxt(); chk("coinc_rd_bank", int'(rd_bank), 1);
    read_check(2, 102, "coinc_old");
    rd_frame_start = 1'b1;
    nxt(); chk("coinc_swap", int'(rd_bank), 0);
    read_check(2, 202, "coinc_new");

    // Out-of-range write and read.
    nxt(); wr_frame_start = 1'b1;
    nxt(); wr_en = 1'b1; wr_addr = 5'd16; wr_data = 12'h555;
    nxt(); chk("oob_pulse", int'(wr_oob), 1);
    nxt(); chk("oob_clear", int'(wr_oob), 0);
    read_check(16, 0, "oob_read");

    // Reset while ACTIVE with reads streaming.
    repeat (3) begin rd_en = 1'b1; rd_addr = 5'd5; nxt(); end
    chk("pre_rst_pixel", int'(vga_pixel), 205);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_pixel", int'(vga_pixel), 0);
    chk("arst_vld", int'(vga_pixel_vld), 0);
    chk("arst_avail", int'(frame_avail), 0);
    chk("arst_wr_bank", int'(wr_bank), 0);
    chk("arst_rd_bank", int'(rd_bank), 1);
    @(negedge clk); rst_n = 1'b1;
    nxt();
    read_check(5, 0, "post_rst_blank");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      nxt();
      wr_frame_start = ($urandom_range(0, 9) == 0);
      wr_frame_done  = ($urandom_range(0, 11) == 0);
      rd_frame_start = ($urandom_range(0, 14) == 0);
      wr_en   = $urandom_range(0, 1) != 0;
      wr_addr = ADDR_W'($urandom_range(0, 17));
      wr_data = DATA_W'($urandom_range(0, 4095));
      rd_en   = $urandom_range(0, 1) != 0;
      rd_addr = ADDR_W'($urandom_range(0, 17));
    end
    nxt(); nxt(); nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
